bcd_tick_counter: RTL and testbench
===================================

Name: bcd_tick_counter

Overview:
Downstream consumer of the pulse divider's O_CLK output. Samples the slow divided clock as a data signal in the fast I_CLK domain and detects its rising edges. Counts those edges in a 4-bit modulo-MOD up/down counter (decade by default). Drives a registered 7-segment pattern and a carry/borrow pulse for cascading further digits.

Parameters:
MOD, 10, counter modulus; legal range 2..16; count range 0..MOD-1.
SYNC_STAGES, 2, synchronizer depth on I_TICK; legal range 2..3.
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (common-anode); 0 = lit when 1.

Ports:
I_CLK  input  1  system clock; the only clock in the block.
I_RST  input  1  synchronous, active-high reset.
I_TICK  input  1  divided clock from the pulse divider; treated as asynchronous level.
I_EN  input  1  count enable; steps arriving while low are dropped, not queued.
I_UP  input  1  direction: 1 = up, 0 = down.
I_LOAD  input  1  synchronous load strobe.
I_LOAD_VAL  input  4  value loaded on I_LOAD.
O_Q  output  4  current count, binary 0..MOD-1.
O_CARRY  output  1  one-cycle pulse on wrap, either direction.
O_SEG  output  7  segments {g,f,e,d,c,b,a} for O_Q.

Behaviour:
- Clock and reset: one clock, I_CLK. Reset is synchronous and active-high on I_RST. All state changes occur on the rising edge of I_CLK.
- Reset values: O_Q=0, O_CARRY=0, O_SEG=glyph "0" (0x40 when SEG_ACTIVE_LOW=1, 0x3F when 0). Sync chain and edge history cleared. Arm FSM = DISARMED.
- Tick path: I_TICK passes through SYNC_STAGES flops, then a history flop. step = synced & ~history & ARMED.
- Arm FSM, two states:
  - DISARMED -> ARMED when synced output is 0.
  - ARMED stays ARMED until reset.
  - Purpose: a tick held high through reset produces no spurious step.
- Latency: I_TICK rising with setup met before edge k gives step during cycle k+SYNC_STAGES-1. O_Q, O_CARRY and O_SEG update at edge k+SYNC_STAGES (3rd edge for default 2 stages).
- Priority per edge: I_RST > I_LOAD > (step & I_EN).
- Load: O_Q <= I_LOAD_VAL if I_LOAD_VAL < MOD, else O_Q <= 0. O_CARRY=0 that cycle. A coincident step is dropped.
- Up step: O_Q==MOD-1 gives O_Q<=0 and O_CARRY=1; otherwise O_Q+1.
- Down step: O_Q==0 gives O_Q<=MOD-1 and O_CARRY=1; otherwise O_Q-1.
- O_CARRY is high exactly one cycle, registered, aligned with the O_Q change. It is 0 in all other cycles.
- I_UP is sampled only in a step cycle; changing it between steps has no other effect.
- O_SEG is registered and decoded from the next-state O_Q, so it is always consistent with O_Q in the same cycle. Glyphs are hex 0-F; A-F only reachable when MOD>10. Polarity per SEG_ACTIVE_LOW.
- Minimum tick spacing: I_TICK high and low phases must each be ≥ SYNC_STAGES+1 I_CLK cycles, or edges may be lost. No other rate limit.
- Reset mid-count: next cycle returns to reset values. Any step in flight in the sync chain is discarded.

Decomposition:
- Shared package: SEG_PATTERN[0:15] constant table (active-high form, inverted in the block per SEG_ACTIVE_LOW), DEFAULT_MOD=10, arm-state encoding (DISARMED=0, ARMED=1).
- One sub-module: tick_edge_sync, containing the synchronizer, history flop and arm FSM. Ports: I_CLK, I_RST, I_TICK, O_STEP.
- Counter, wrap logic and segment register stay in bcd_tick_counter.

Test Plan:
- Reset then 12 I_TICK periods (20 cycles high / 20 low), I_UP=1, I_EN=1 -> O_Q sequence 1..9,0,1,2; O_CARRY exactly one 1-cycle pulse at the 9->0 step; O_SEG=0x40 whenever O_Q=0; each step 3 edges after I_TICK rise.
- I_UP=0 from O_Q=0, 3 ticks -> O_Q 9,8,7; O_CARRY pulses only on the 0->9 step.
- I_TICK held high across reset release -> O_Q stays 0 until I_TICK goes low then high; first step then gives O_Q=1.
- I_LOAD with I_LOAD_VAL=7 in the same cycle as a step -> O_Q=7, no increment, O_CARRY=0. I_LOAD_VAL=12 -> O_Q=0.
- I_EN=0 during 2 ticks, then I_EN=1 and 1 tick -> O_Q increments by exactly 1.
- MOD=6, SEG_ACTIVE_LOW=0, 7 up ticks from 0 -> O_Q 1..5,0,1; carry on 5->0; O_SEG=0x6D at O_Q=5.

Source files
------------

// File: rtl/bcd_tick_counter_pkg.sv
// Shared constants for the BCD tick counter: segment glyphs, default modulus
// and the arm-state encoding used by the tick edge synchronizer.
package bcd_tick_counter_pkg;

  localparam int DEFAULT_MOD = 10;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}, hex digits 0..F
  localparam logic [6:0] SEG_PATTERN [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_e;

endpackage

// File: rtl/bcd_tick_counter_sync.sv
// Synchronizes the asynchronous divided clock, detects its rising edges and
// suppresses the edge of a tick that was already high when reset released.
module tick_edge_sync
  import bcd_tick_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_TICK,
  output logic O_STEP
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   hist_q;
  logic                   synced;
  arm_state_e             state_q, state_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      state_q <= DISARMED;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], I_TICK};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= synced;
      state_q <= state_d;
    end
  end

  // The cleared chain reads 0 regardless of I_TICK, so arming waits until the
  // chain has been refilled with real samples after reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISARMED: if (fill_q[SYNC_STAGES-1] && !synced) state_d = ARMED;
      ARMED:    state_d = ARMED;
      default:  state_d = DISARMED;
    endcase
  end

  assign O_STEP = synced & ~hist_q & (state_q == ARMED);

endmodule

// File: rtl/bcd_tick_counter.sv
// Modulo-MOD up/down digit counter stepped by rising edges of the divided
// clock, with registered 7-segment output and a carry/borrow pulse.
module bcd_tick_counter
  import bcd_tick_counter_pkg::*;
#(
  parameter int MOD            = DEFAULT_MOD,
  parameter int SYNC_STAGES    = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_TICK,
  input  logic       I_EN,
  input  logic       I_UP,
  input  logic       I_LOAD,
  input  logic [3:0] I_LOAD_VAL,
  output logic [3:0] O_Q,
  output logic       O_CARRY,
  output logic [6:0] O_SEG
);

  localparam logic [3:0] MAX_Q    = 4'(MOD - 1);
  localparam logic [4:0] MOD_V    = 5'(MOD);
  localparam logic [6:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic       step;
  logic [3:0] q_q, q_d;
  logic       carry_q, carry_d;
  logic [6:0] seg_q, seg_d;

  tick_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .I_CLK (I_CLK),
    .I_RST (I_RST),
    .I_TICK(I_TICK),
    .O_STEP(step)
  );

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    if (I_LOAD) begin
      q_d = ({1'b0, I_LOAD_VAL} < MOD_V) ? I_LOAD_VAL : 4'd0;
    end else if (step && I_EN) begin
      if (I_UP) begin
        if (q_q == MAX_Q) begin
          q_d     = 4'd0;
          carry_d = 1'b1;
        end else begin
          q_d = q_q + 4'd1;
        end
      end else begin
        if (q_q == 4'd0) begin
          q_d     = MAX_Q;
          carry_d = 1'b1;
        end else begin
          q_d = q_q - 4'd1;
        end
      end
    end
    // Decoding the next state keeps the segment register in step with O_Q.
    seg_d = SEG_PATTERN[q_d] ^ SEG_MASK;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      q_q     <= 4'd0;
      carry_q <= 1'b0;
      seg_q   <= SEG_PATTERN[0] ^ SEG_MASK;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
    end
  end

  assign O_Q     = q_q;
  assign O_CARRY = carry_q;
  assign O_SEG   = seg_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench: decade counter with active-low segments, plus a MOD=6
// instance with active-high segments driven by its own tick.
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst, tick, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q1;
  logic       c1;
  logic [6:0] s1;

  logic       rst2, tick2, en2, up2, load2;
  logic [3:0] load_val2;
  logic [3:0] q2;
  logic       c2;
  logic [6:0] s2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_tick_counter dut (
    .I_CLK(clk), .I_RST(rst), .I_TICK(tick), .I_EN(en), .I_UP(up),
    .I_LOAD(load), .I_LOAD_VAL(load_val), .O_Q(q1), .O_CARRY(c1), .O_SEG(s1)
  );

  bcd_tick_counter #(.MOD(6), .SYNC_STAGES(2), .SEG_ACTIVE_LOW(0)) dut6 (
    .I_CLK(clk), .I_RST(rst2), .I_TICK(tick2), .I_EN(en2), .I_UP(up2),
    .I_LOAD(load2), .I_LOAD_VAL(load_val2), .O_Q(q2), .O_CARRY(c2), .O_SEG(s2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_hi(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_exp(input bit sel, input logic [3:0] v);
    return sel ? {1'b0, seg_hi(v)} : {1'b0, ~seg_hi(v)};
  endfunction

  // One 20-high/20-low tick period; called on a falling edge.
  task automatic do_tick(input bit sel, input logic [3:0] prev, input logic [3:0] exp_q,
                         input logic exp_c, input string tag);
    if (sel) tick2 = 1'b1; else tick = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_lat"}, {4'b0, sel ? q2 : q1}, {4'b0, prev});
    chk({tag, "_latc"}, {7'b0, sel ? c2 : c1}, 8'h00);
    @(negedge clk);
    chk({tag, "_q"}, {4'b0, sel ? q2 : q1}, {4'b0, exp_q});
    chk({tag, "_c"}, {7'b0, sel ? c2 : c1}, {7'b0, exp_c});
    chk({tag, "_seg"}, {1'b0, sel ? s2 : s1}, seg_exp(sel, exp_q));
    @(negedge clk);
    chk({tag, "_c1cyc"}, {7'b0, sel ? c2 : c1}, 8'h00);
    repeat (16) @(negedge clk);
    if (sel) tick2 = 1'b0; else tick = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [3:0] prev;
    rst = 1'b1; tick = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
    rst2 = 1'b1; tick2 = 1'b0; en2 = 1'b1; up2 = 1'b1; load2 = 1'b0; load_val2 = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", {4'b0, q1}, 8'h00);
    chk("rst_c", {7'b0, c1}, 8'h00);
    chk("rst_seg", {1'b0, s1}, 8'h40);
    chk("rst_seg6", {1'b0, s2}, 8'h3F);
    rst = 1'b0; rst2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_q", {4'b0, q1}, 8'h00);

    // 12 up ticks: 1..9,0,1,2 with carry only on 9->0
    prev = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      do_tick(1'b0, prev, 4'(i % 10), (i == 10), $sformatf("up%0d", i));
      prev = 4'(i % 10);
    end

    // Back to 0, then count down 9,8,7
    load = 1'b1; load_val = 4'd0;
    @(negedge clk);
    load = 1'b0;
    chk("ld0_q", {4'b0, q1}, 8'h00);
    up = 1'b0;
    do_tick(1'b0, 4'd0, 4'd9, 1'b1, "dn9");
    do_tick(1'b0, 4'd9, 4'd8, 1'b0, "dn8");
    do_tick(1'b0, 4'd8, 4'd7, 1'b0, "dn7");
    up = 1'b1;

    // Tick held high across reset release must not step
    tick = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("hr_rst_q", {4'b0, q1}, 8'h00);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("hr_high_q", {4'b0, q1}, 8'h00);
    tick = 1'b0;
    repeat (20) @(negedge clk);
    chk("hr_low_q", {4'b0, q1}, 8'h00);
    do_tick(1'b0, 4'd0, 4'd1, 1'b0, "hr_first");

    // Load coincident with a step: load wins, step dropped
    tick = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b1; load_val = 4'd7;
    @(negedge clk);
    load = 1'b0;
    chk("ldstep_q", {4'b0, q1}, 8'h07);
    chk("ldstep_c", {7'b0, c1}, 8'h00);
    chk("ldstep_seg", {1'b0, s1}, seg_exp(1'b0, 4'd7));
    @(negedge clk);
    chk("ldstep_hold", {4'b0, q1}, 8'h07);
    repeat (17) @(negedge clk);
    tick = 1'b0;
    repeat (20) @(negedge clk);

    // Out-of-range load value clamps to 0
    load = 1'b1; load_val = 4'd12;
    @(negedge clk);
    load = 1'b0;
    chk("ld12_q", {4'b0, q1}, 8'h00);
    chk("ld12_seg", {1'b0, s1}, 8'h40);

    // Disabled ticks are dropped
    en = 1'b0;
    do_tick(1'b0, 4'd0, 4'd0, 1'b0, "en0a");
    do_tick(1'b0, 4'd0, 4'd0, 1'b0, "en0b");
    en = 1'b1;
    do_tick(1'b0, 4'd0, 4'd1, 1'b0, "en1");

    // Six-state instance, active-high segments: 1..5,0,1 with carry on 5->0
    prev = 4'd0;
    for (int i = 1; i <= 7; i++) begin
      do_tick(1'b1, prev, 4'(i % 6), (i == 6), $sformatf("m6_%0d", i));
      prev = 4'(i % 6);
    end
    chk("m6_dut1_still", {4'b0, q1}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
